// File: rtl/ysyx_24110006_rd_arbiter.sv
// Two-master AXI4-Lite read arbiter: IFU (master 0) and LSU (master 1) share one
// memory read port, one outstanding read at a time, no data buffering.
module ysyx_24110006_rd_arbiter #(
    parameter bit FAIR = 1'b1
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic [31:0] i_ifu_araddr,
    input  logic        i_ifu_arvalid,
    output logic        o_ifu_arready,
    output logic [31:0] o_ifu_rdata,
    output logic [1:0]  o_ifu_rresp,
    output logic        o_ifu_rvalid,
    input  logic        i_ifu_rready,
    input  logic [31:0] i_lsu_araddr,
    input  logic        i_lsu_arvalid,
    output logic        o_lsu_arready,
    output logic [31:0] o_lsu_rdata,
    output logic [1:0]  o_lsu_rresp,
    output logic        o_lsu_rvalid,
    input  logic        i_lsu_rready,
    output logic [31:0] o_mem_araddr,
    output logic        o_mem_arvalid,
    input  logic        i_mem_arready,
    input  logic [31:0] i_mem_rdata,
    input  logic [1:0]  i_mem_rresp,
    input  logic        i_mem_rvalid,
    output logic        o_mem_rready
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        IFU_AR = 3'd1,
        IFU_R  = 3'd2,
        LSU_AR = 3'd3,
        LSU_R  = 3'd4
    } state_t;

    localparam logic MST_IFU = 1'b0;
    localparam logic MST_LSU = 1'b1;

    state_t state, state_nxt;
    logic   last, last_nxt;
    logic   grant_lsu;

    // On a tie, round-robin hands the port to whoever did not have it last.
    assign grant_lsu = i_lsu_arvalid &&
                       (!i_ifu_arvalid || !FAIR || (last == MST_IFU));

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= IDLE;
            last  <= MST_LSU;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        case (state)
            IDLE: begin
                if (grant_lsu) begin
                    state_nxt = LSU_AR;
                    last_nxt  = MST_LSU;
                end else if (i_ifu_arvalid) begin
                    state_nxt = IFU_AR;
                    last_nxt  = MST_IFU;
                end
            end
            IFU_AR: if (i_ifu_arvalid && i_mem_arready) state_nxt = IFU_R;
            IFU_R:  if (i_mem_rvalid && i_ifu_rready)   state_nxt = IDLE;
            LSU_AR: if (i_lsu_arvalid && i_mem_arready) state_nxt = LSU_R;
            LSU_R:  if (i_mem_rvalid && i_lsu_rready)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_ifu_arready = 1'b0;
        o_ifu_rdata   = '0;
        o_ifu_rresp   = '0;
        o_ifu_rvalid  = 1'b0;
        o_lsu_arready = 1'b0;
        o_lsu_rdata   = '0;
        o_lsu_rresp   = '0;
        o_lsu_rvalid  = 1'b0;
        o_mem_araddr  = '0;
        o_mem_arvalid = 1'b0;
        o_mem_rready  = 1'b0;
        case (state)
            IFU_AR: begin
                o_mem_araddr  = i_ifu_araddr;
                o_mem_arvalid = i_ifu_arvalid;
                o_ifu_arready = i_mem_arready;
            end
            IFU_R: begin
                o_ifu_rdata  = i_mem_rdata;
                o_ifu_rresp  = i_mem_rresp;
                o_ifu_rvalid = i_mem_rvalid;
                o_mem_rready = i_ifu_rready;
            end
            LSU_AR: begin
                o_mem_araddr  = i_lsu_araddr;
                o_mem_arvalid = i_lsu_arvalid;
                o_lsu_arready = i_mem_arready;
            end
            LSU_R: begin
                o_lsu_rdata  = i_mem_rdata;
                o_lsu_rresp  = i_mem_rresp;
                o_lsu_rvalid = i_mem_rvalid;
                o_mem_rready = i_lsu_rready;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ysyx_24110006_rd_arbiter.sv
// Directed per-cycle vector bench for the read arbiter: round-robin instance driven
// from a table, fixed-priority instance exercised by a short hand sequence.
module tb_ysyx_24110006_rd_arbiter;

    typedef struct packed {
        logic        rst;
        logic        iv;
        logic [31:0] ia;
        logic        irr;
        logic        lv;
        logic [31:0] la;
        logic        lrr;
        logic        mar;
        logic [31:0] md;
        logic [1:0]  mr;
        logic        mv;
    } in_t;

    typedef struct packed {
        logic        ifar;
        logic        ifrv;
        logic [31:0] ifd;
        logic [1:0]  ifr;
        logic        lar;
        logic        lrv;
        logic [31:0] ld;
        logic [1:0]  lr;
        logic [31:0] ma;
        logic        mav;
        logic        mrr;
    } out_t;

    typedef struct {
        string name;
        in_t   i;
        out_t  o;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    in_t  cur;
    out_t act_f, act_p;
    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    ysyx_24110006_rd_arbiter #(.FAIR(1'b1)) dut_f (
        .i_clock(clk), .i_reset(cur.rst),
        .i_ifu_araddr(cur.ia), .i_ifu_arvalid(cur.iv), .o_ifu_arready(act_f.ifar),
        .o_ifu_rdata(act_f.ifd), .o_ifu_rresp(act_f.ifr), .o_ifu_rvalid(act_f.ifrv),
        .i_ifu_rready(cur.irr),
        .i_lsu_araddr(cur.la), .i_lsu_arvalid(cur.lv), .o_lsu_arready(act_f.lar),
        .o_lsu_rdata(act_f.ld), .o_lsu_rresp(act_f.lr), .o_lsu_rvalid(act_f.lrv),
        .i_lsu_rready(cur.lrr),
        .o_mem_araddr(act_f.ma), .o_mem_arvalid(act_f.mav), .i_mem_arready(cur.mar),
        .i_mem_rdata(cur.md), .i_mem_rresp(cur.mr), .i_mem_rvalid(cur.mv),
        .o_mem_rready(act_f.mrr)
    );

    ysyx_24110006_rd_arbiter #(.FAIR(1'b0)) dut_p (
        .i_clock(clk), .i_reset(cur.rst),
        .i_ifu_araddr(cur.ia), .i_ifu_arvalid(cur.iv), .o_ifu_arready(act_p.ifar),
        .o_ifu_rdata(act_p.ifd), .o_ifu_rresp(act_p.ifr), .o_ifu_rvalid(act_p.ifrv),
        .i_ifu_rready(cur.irr),
        .i_lsu_araddr(cur.la), .i_lsu_arvalid(cur.lv), .o_lsu_arready(act_p.lar),
        .o_lsu_rdata(act_p.ld), .o_lsu_rresp(act_p.lr), .o_lsu_rvalid(act_p.lrv),
        .i_lsu_rready(cur.lrr),
        .o_mem_araddr(act_p.ma), .o_mem_arvalid(act_p.mav), .i_mem_arready(cur.mar),
        .i_mem_rdata(cur.md), .i_mem_rresp(cur.mr), .i_mem_rvalid(cur.mv),
        .o_mem_rready(act_p.mrr)
    );

    function automatic in_t mi(logic rst, logic iv, logic [31:0] ia, logic irr,
                               logic lv, logic [31:0] la, logic lrr, logic mar,
                               logic [31:0] md, logic [1:0] mr, logic mv);
        in_t v;
        v = '{rst, iv, ia, irr, lv, la, lrr, mar, md, mr, mv};
        return v;
    endfunction

    function automatic out_t mo(logic ifar, logic ifrv, logic [31:0] ifd, logic [1:0] ifr,
                                logic lar, logic lrv, logic [31:0] ld, logic [1:0] lr,
                                logic [31:0] ma, logic mav, logic mrr);
        out_t v;
        v = '{ifar, ifrv, ifd, ifr, lar, lrv, ld, lr, ma, mav, mrr};
        return v;
    endfunction

    function automatic void add(string n, in_t i, out_t o);
        vec_t v;
        v.name = n;
        v.i    = i;
        v.o    = o;
        tbl.push_back(v);
    endfunction

    // Drive at the falling edge, compare once the combinational outputs settle.
    task automatic step(input vec_t v, input bit use_p);
        out_t a;
        @(negedge clk);
        cur = v.i;
        #1;
        a = use_p ? act_p : act_f;
        n_vec++;
        if (a !== v.o) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", v.name, a, v.o);
        end
    endtask

    localparam out_t Z = '0;

    initial begin
        vec_t v;
        add("idle",         mi(0,0,0,0,0,0,0,0,0,0,0), Z);
        add("ifu_req",      mi(0,1,32'h8000_0000,0,0,0,0,0,0,0,0), Z);
        add("ifu_ar",       mi(0,1,32'h8000_0000,0,0,0,0,1,0,0,0),
                            mo(1,0,0,0,0,0,0,0,32'h8000_0000,1,0));
        add("ifu_r",        mi(0,0,0,1,0,0,0,0,32'h0000_0413,0,1),
                            mo(0,1,32'h0000_0413,0,0,0,0,0,0,0,1));
        add("stray_rvalid", mi(0,0,0,0,0,0,0,0,32'hdead_beef,0,1), Z);
        add("reset",        mi(1,0,0,0,0,0,0,0,0,0,0), Z);
        add("tie1",         mi(0,1,32'h8000_0004,0,1,32'h8000_1000,0,0,0,0,0), Z);
        add("tie1_ar_ifu",  mi(0,1,32'h8000_0004,0,1,32'h8000_1000,0,1,0,0,0),
                            mo(1,0,0,0,0,0,0,0,32'h8000_0004,1,0));
        add("tie1_r_ifu",   mi(0,1,32'h8000_0008,1,1,32'h8000_1000,0,0,32'h11,0,1),
                            mo(0,1,32'h11,0,0,0,0,0,0,0,1));
        add("tie2",         mi(0,1,32'h8000_0008,0,1,32'h8000_1000,0,0,0,0,0), Z);
        add("tie2_ar_lsu",  mi(0,1,32'h8000_0008,0,1,32'h8000_1000,0,1,0,0,0),
                            mo(0,0,0,0,1,0,0,0,32'h8000_1000,1,0));
        add("tie2_r_lsu",   mi(0,1,32'h8000_0008,0,1,32'h8000_1004,1,0,32'h22,0,1),
                            mo(0,0,0,0,0,1,32'h22,0,0,0,1));
        add("tie3",         mi(0,1,32'h8000_0008,0,1,32'h8000_1004,0,0,0,0,0), Z);
        add("tie3_ar_ifu",  mi(0,1,32'h8000_0008,0,1,32'h8000_1004,0,1,0,0,0),
                            mo(1,0,0,0,0,0,0,0,32'h8000_0008,1,0));
        add("tie3_r_ifu",   mi(0,0,0,1,1,32'h8000_1004,0,0,32'h33,0,1),
                            mo(0,1,32'h33,0,0,0,0,0,0,0,1));
        add("lsu_only",     mi(0,0,0,0,1,32'h8000_1004,0,0,0,0,0), Z);
        add("lsu_ar_stall", mi(0,1,32'h8000_000c,0,1,32'h8000_1004,0,0,0,0,0),
                            mo(0,0,0,0,0,0,0,0,32'h8000_1004,1,0));
        add("lsu_ar_drop",  mi(0,1,32'h8000_000c,0,0,32'h8000_1004,0,1,0,0,0),
                            mo(0,0,0,0,1,0,0,0,32'h8000_1004,0,0));
        add("lsu_ar_hs",    mi(0,1,32'h8000_000c,0,1,32'h8000_1004,0,1,0,0,0),
                            mo(0,0,0,0,1,0,0,0,32'h8000_1004,1,0));
        for (int k = 0; k < 5; k++)
            add("lsu_r_bp", mi(0,1,32'h8000_000c,0,0,0,0,0,32'h44,2'b10,1),
                            mo(0,0,0,0,0,1,32'h44,2'b10,0,0,0));
        add("lsu_r_slverr", mi(0,1,32'h8000_000c,0,0,0,1,0,32'h44,2'b10,1),
                            mo(0,0,0,0,0,1,32'h44,2'b10,0,0,1));
        add("ifu_pending",  mi(0,1,32'h8000_000c,0,0,0,0,0,0,0,0), Z);
        add("ifu_ar2",      mi(0,1,32'h8000_000c,0,0,0,0,1,0,0,0),
                            mo(1,0,0,0,0,0,0,0,32'h8000_000c,1,0));
        add("ifu_r_wait",   mi(0,0,0,1,0,0,0,0,0,0,0),
                            mo(0,0,0,0,0,0,0,0,0,0,1));
        add("rst_in_ifu_r", mi(1,0,0,1,0,0,0,0,0,0,0),
                            mo(0,0,0,0,0,0,0,0,0,0,1));
        add("post_rst",     mi(0,0,0,0,0,0,0,0,32'h55,0,1), Z);
        add("fresh_ifu",    mi(0,1,32'h8000_0010,0,0,0,0,0,0,0,0), Z);
        add("fresh_ar",     mi(0,1,32'h8000_0010,0,0,0,0,1,0,0,0),
                            mo(1,0,0,0,0,0,0,0,32'h8000_0010,1,0));
        add("fresh_r",      mi(0,0,0,1,0,0,0,0,32'h66,0,1),
                            mo(0,1,32'h66,0,0,0,0,0,0,0,1));
        add("fresh_done",   mi(0,0,0,0,0,0,0,0,0,0,0), Z);

        cur = mi(1,0,0,0,0,0,0,0,0,0,0);
        repeat (2) @(posedge clk);

        foreach (tbl[k]) step(tbl[k], 1'b0);

        // Fixed-priority instance: LSU wins every tie, even right after it was served.
        @(negedge clk);
        cur = mi(1,0,0,0,0,0,0,0,0,0,0);
        @(posedge clk);
        v.name = "p_tie1";
        v.i = mi(0,1,32'h8000_0004,0,1,32'h8000_1000,0,0,0,0,0);
        v.o = Z;
        step(v, 1'b1);
        v.name = "p_ar_lsu";
        v.i = mi(0,1,32'h8000_0004,0,1,32'h8000_1000,0,1,0,0,0);
        v.o = mo(0,0,0,0,1,0,0,0,32'h8000_1000,1,0);
        step(v, 1'b1);
        v.name = "p_r_lsu";
        v.i = mi(0,1,32'h8000_0004,0,1,32'h8000_1008,1,0,32'h77,0,1);
        v.o = mo(0,0,0,0,0,1,32'h77,0,0,0,1);
        step(v, 1'b1);
        v.name = "p_tie2";
        v.i = mi(0,1,32'h8000_0004,0,1,32'h8000_1008,0,0,0,0,0);
        v.o = Z;
        step(v, 1'b1);
        v.name = "p_ar_lsu2";
        v.i = mi(0,1,32'h8000_0004,0,1,32'h8000_1008,0,1,0,0,0);
        v.o = mo(0,0,0,0,1,0,0,0,32'h8000_1008,1,0);
        step(v, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
